// File: rtl/step_pkg.sv
// Shared types and helpers for the stepper scheduler.
package step_pkg;

    localparam int unsigned STEP_W = 2;

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StCheck,
        StDone
    } state_e;

    // Pulses needed to move the stepper output from cur to tgt (2-bit wrap).
    function automatic logic [STEP_W-1:0] step_dist(input logic [STEP_W-1:0] tgt,
                                                    input logic [STEP_W-1:0] cur);
        return tgt - cur;
    endfunction

endpackage

// File: rtl/step_sched_if.sv
// Request/target/stepper bundle between the requesters, the stepper and step_sched.
interface step_sched_if;
    import step_pkg::*;

    logic [1:0]        req;
    logic [STEP_W-1:0] tgt_a;
    logic [STEP_W-1:0] tgt_b;
    logic [STEP_W-1:0] cur_out;
    logic              step;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic              busy;
    logic              err;

    modport slave (
        input  req, tgt_a, tgt_b, cur_out,
        output step, gnt, done, busy, err
    );

    modport master (
        output req, tgt_a, tgt_b, cur_out,
        input  step, gnt, done, busy, err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr_i selects which requester wins a tie.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       rr_i,
    output logic [1:0] gnt_o,
    output logic       valid_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = rr_i ? 2'b10 : 2'b01;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/step_sched.sv
// Grants the shared stepper to one of two requesters and steps it to the latched target.
// The stepper feeding cur_out must be reset by the same rst_i event.
module step_sched
    import step_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic  clk_i,
    input  logic  rst_i,
    step_sched_if.slave bus
);

    state_e            state_q, state_d;
    logic              g_q, g_d;
    logic [STEP_W-1:0] tgt_q, tgt_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic              err_q, err_d;

    logic [1:0] win;
    logic       win_valid;
    logic [1:0] g_onehot;

    rr_arb2 u_arb (
        .req_i   (bus.req),
        .rr_i    (rr_q),
        .gnt_o   (win),
        .valid_o (win_valid)
    );

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    g_d     = win[1];
                    tgt_d   = win[1] ? bus.tgt_b : bus.tgt_a;
                    cnt_d   = step_dist(tgt_d, bus.cur_out);
                    state_d = (cnt_d != '0) ? StStep : StCheck;
                end
            end
            StStep: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 2'd1) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (CHECK_EN && (bus.cur_out != tgt_q)) begin
                    err_d = 1'b1;
                end
                state_d = StDone;
            end
            StDone: begin
                rr_d    = ~g_q;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            g_q     <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    assign g_onehot = g_q ? 2'b10 : 2'b01;
    assign bus.step = (state_q == StStep);
    assign bus.busy = (state_q != StIdle);
    assign bus.gnt  = bus.busy ? g_onehot : 2'b00;
    assign bus.done = (state_q == StDone) ? g_onehot : 2'b00;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_step_sched.sv
// Bench for step_sched: two DUTs (compare on/off) each driving its own stepper model.
module tb_step_sched;
    import step_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] req;
    logic [1:0] tgt_a;
    logic [1:0] tgt_b;
    logic       skip_req;
    logic       skip_used;
    logic       load_en;
    logic [1:0] load_val;
    logic [1:0] st1, st0;

    step_sched_if bus1 ();
    step_sched_if bus0 ();

    assign bus1.req     = req;
    assign bus1.tgt_a   = tgt_a;
    assign bus1.tgt_b   = tgt_b;
    assign bus1.cur_out = st1 + 2'd1;
    assign bus0.req     = req;
    assign bus0.tgt_a   = tgt_a;
    assign bus0.tgt_b   = tgt_b;
    assign bus0.cur_out = st0 + 2'd1;

    step_sched #(.CHECK_EN(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));
    step_sched #(.CHECK_EN(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));

    // Stepper models; skip_req swallows exactly one step pulse while held.
    always @(posedge clk) begin
        if (rst) begin
            st1       <= 2'd0;
            st0       <= 2'd0;
            skip_used <= 1'b0;
        end else if (load_en) begin
            st1 <= load_val - 2'd1;
            st0 <= load_val - 2'd1;
        end else begin
            if (!skip_req) skip_used <= 1'b0;
            if (bus1.step && skip_req && !skip_used) skip_used <= 1'b1;
            if (bus1.step && !(skip_req && !skip_used)) st1 <= st1 + 2'd1;
            if (bus0.step && !(skip_req && !skip_used)) st0 <= st0 + 2'd1;
        end
    end

    int checks;
    int errors;
    bit m_rr;
    int m_pos;
    bit m_err;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    // Expected per-cycle {step, gnt, done, busy, err(chk on), err(chk off)} for one grant.
    task automatic model_txn(input logic [1:0] reqv, input bit skip, output int n);
        int w, tgt, fin;
        bit new_err;
        logic [1:0] oh, e_gnt, e_done;
        logic e_step, e_busy, e_err;
        if (reqv == 2'b11) w = m_rr ? 1 : 0;
        else w = reqv[1] ? 1 : 0;
        tgt = (w == 1) ? int'(tgt_b) : int'(tgt_a);
        n = (tgt + 4 - m_pos) % 4;
        fin = (skip && n > 0) ? (tgt + 3) % 4 : tgt;
        new_err = m_err || (fin != tgt);
        oh = (w == 1) ? 2'b10 : 2'b01;
        for (int k = 1; k <= n + 3; k++) begin
            e_step = (k <= n);
            e_busy = (k <= n + 2);
            e_gnt  = e_busy ? oh : 2'b00;
            e_done = (k == n + 2) ? oh : 2'b00;
            e_err  = (k >= n + 2) ? new_err : m_err;
            exp_q.push_back({e_step, e_gnt, e_done, e_busy, e_err, 1'b0});
        end
        m_rr  = (w == 0);
        m_pos = fin;
        m_err = new_err;
    endtask

    task automatic model_idle();
        exp_q.push_back({6'b0, m_err, 1'b0});
    endtask

    task automatic run(input int ncyc, input int drop_at, input bit scramble);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            obs_q.push_back({bus1.step, bus1.gnt, bus1.done, bus1.busy, bus1.err, bus0.err});
            if (k == drop_at) req = 2'b00;
            if (scramble && k == 1) begin
                tgt_a = 2'($urandom_range(0, 3));
                tgt_b = 2'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic set_cur(input logic [1:0] v);
        load_val = v;
        load_en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_en = 1'b0;
        m_pos   = int'(v);
    endtask

    task automatic test_reset();
        logic [7:0] e, o;
        rst = 1'b1;
        req = 2'b11;
        model_idle();
        model_idle();
        run(2, 2, 1'b0);
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset: got %b want %b", o, e);
            end
        end
    endtask

    task automatic test_single_a();
        logic [7:0] e, o;
        int n;
        tgt_a = 2'd2;
        req   = 2'b01;
        model_txn(req, 1'b0, n);
        run(n + 3, 1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_a: got %b want %b", o, e);
            end
        end
    endtask

    task automatic test_single_b3();
        logic [7:0] e, o;
        int n;
        set_cur(2'd0);
        tgt_b = 2'd3;
        req   = 2'b10;
        model_txn(req, 1'b0, n);
        run(n + 3, n + 3, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_b3: got %b want %b", o, e);
            end
        end
    endtask

    task automatic test_contention();
        logic [7:0] e, o;
        int n;
        tgt_a = 2'd0;
        tgt_b = 2'd2;
        req   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            model_txn(2'b11, 1'b0, n);
            run(n + 3, (i == 3) ? n + 3 : 0, 1'b0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL contention: got %b want %b", o, e);
            end
        end
    endtask

    task automatic test_zero_and_wrap();
        logic [7:0] e, o;
        int n;
        set_cur(2'd2);
        tgt_a = 2'd2;
        req   = 2'b01;
        model_txn(req, 1'b0, n);
        run(n + 3, n + 3, 1'b0);
        set_cur(2'd3);
        tgt_a = 2'd0;
        req   = 2'b01;
        model_txn(req, 1'b0, n);
        run(n + 3, n + 3, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL zero_wrap: got %b want %b", o, e);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] e, o;
        int n;
        for (int i = 0; i < 30; i++) begin
            req   = 2'($urandom_range(1, 3));
            tgt_a = 2'($urandom_range(0, 3));
            tgt_b = 2'($urandom_range(0, 3));
            model_txn(req, 1'b0, n);
            run(n + 3, int'($urandom_range(1, n + 3)), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                model_idle();
                run(1, 0, 1'b0);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random: got %b want %b", o, e);
            end
        end
    endtask

    task automatic test_err();
        logic [7:0] e, o;
        int n;
        set_cur(2'd0);
        skip_req = 1'b1;
        tgt_a    = 2'd2;
        req      = 2'b01;
        model_txn(req, 1'b1, n);
        run(n + 3, n + 3, 1'b0);
        skip_req = 1'b0;
        tgt_b    = 2'd3;
        req      = 2'b10;
        model_txn(req, 1'b0, n);
        run(n + 3, n + 3, 1'b0);
        rst   = 1'b1;
        m_err = 1'b0;
        m_rr  = 1'b0;
        m_pos = 1;
        model_idle();
        run(1, 0, 1'b0);
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL err_sticky: got %b want %b", o, e);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] e, o;
        int n;
        tgt_a = 2'd2;
        req   = 2'b01;
        model_txn(req, 1'b0, n);
        run(n + 3, 0, 1'b0);
        tgt_a = 2'd1;
        model_txn(req, 1'b0, n);
        for (int k = 0; k < n + 1; k++) void'(exp_q.pop_back());
        run(2, 0, 1'b0);
        rst   = 1'b1;
        m_rr  = 1'b0;
        m_pos = 1;
        m_err = 1'b0;
        model_idle();
        run(1, 1, 1'b0);
        rst   = 1'b0;
        tgt_a = 2'd3;
        tgt_b = 2'd0;
        req   = 2'b11;
        model_txn(req, 1'b0, n);
        run(n + 3, n + 3, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rst_mid: got %b want %b", o, e);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = 2'b00;
        tgt_a    = 2'd0;
        tgt_b    = 2'd0;
        skip_req = 1'b0;
        load_en  = 1'b0;
        load_val = 2'd0;
        checks   = 0;
        errors   = 0;
        m_rr     = 1'b0;
        m_pos    = 1;
        m_err    = 1'b0;
        test_reset();
        test_single_a();
        test_single_b3();
        test_contention();
        test_zero_and_wrap();
        test_random();
        test_err();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
